// File: rtl/nano_dmem_arbiter_pkg.sv
// Shared types and constants for the nanoCPU data-memory arbiter.
// Holds the FSM state encoding, the port ids and the byte-to-word address slice.
package nano_dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_RR     = 2'd0,
        ST_LOCK_B = 2'd1,
        ST_YIELD  = 2'd2
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int unsigned WADDR_HI = 28;
    localparam int unsigned WADDR_LO = 2;
    localparam int unsigned WADDR_W  = WADDR_HI - WADDR_LO + 1;

    function automatic logic [WADDR_W-1:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr[WADDR_HI:WADDR_LO];
    endfunction

endpackage

// File: rtl/nano_dmem_arbiter_rr_pick.sv
// Two-input round-robin selector: a lone requester wins, a tie goes to the port
// that did not win the most recent grant.
module nano_dmem_arbiter_rr_pick
    import nano_dmem_arbiter_pkg::*;
(
    input  logic i_a_req,
    input  logic i_b_req,
    input  logic i_last_grant,
    output logic o_pick_a,
    output logic o_pick_b
);

    always_comb begin
        o_pick_a = i_a_req & (~i_b_req | (i_last_grant == PORT_B));
        o_pick_b = i_b_req & ~o_pick_a;
    end

endmodule

// File: rtl/nano_dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU (port A) and a DMA/debug
// master (port B): round-robin on conflict, bounded burst lock for B, conflict profiling.
module nano_dmem_arbiter
    import nano_dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_LOCK = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_a_req,
    input  logic              i_a_we,
    input  logic [31:0]       i_a_addr,
    input  logic [31:0]       i_a_wdata,
    output logic              o_a_gnt,
    output logic              o_a_stall,
    output logic [31:0]       o_a_rdata,
    output logic              o_a_rvalid,
    input  logic              i_b_req,
    input  logic              i_b_we,
    input  logic [31:0]       i_b_addr,
    input  logic [31:0]       i_b_wdata,
    input  logic              i_b_lock,
    output logic              o_b_gnt,
    output logic [31:0]       o_b_rdata,
    output logic              o_b_rvalid,
    output logic [26:0]       o_m_addr,
    output logic [31:0]       o_m_wdata,
    output logic              o_m_wr,
    input  logic [31:0]       i_m_rdata,
    output logic [CNT_W-1:0]  o_conflict_cnt
);

    localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

    arb_state_e       r_state;
    logic [7:0]       r_lock_cnt;
    logic             r_last_grant;
    logic [31:0]      r_a_rdata;
    logic [31:0]      r_b_rdata;
    logic             r_a_rvalid;
    logic             r_b_rvalid;
    logic [CNT_W-1:0] r_conflict_cnt;

    logic             w_rr_a;
    logic             w_rr_b;
    logic             w_a_gnt;
    logic             w_b_gnt;
    logic [7:0]       w_lock_inc;
    logic [31:0]      w_own_addr;
    logic             w_unused_addr_bits;

    nano_dmem_arbiter_rr_pick u_rr_pick (
        .i_a_req      (i_a_req),
        .i_b_req      (i_b_req),
        .i_last_grant (r_last_grant),
        .o_pick_a     (w_rr_a),
        .o_pick_b     (w_rr_b)
    );

    // Grants are forced low during reset so no write can slip through that cycle.
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (!i_reset) begin
            case (r_state)
                ST_RR: begin
                    w_a_gnt = w_rr_a;
                    w_b_gnt = w_rr_b;
                end
                ST_LOCK_B: begin
                    w_b_gnt = i_b_req;
                    w_a_gnt = i_a_req & ~i_b_req;
                end
                ST_YIELD: begin
                    w_a_gnt = i_a_req;
                    w_b_gnt = i_b_req & ~i_a_req;
                end
                default: begin
                    w_a_gnt = 1'b0;
                    w_b_gnt = 1'b0;
                end
            endcase
        end
    end

    assign w_lock_inc = r_lock_cnt + 8'd1;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_RR;
            r_lock_cnt   <= 8'd0;
            r_last_grant <= PORT_B;
        end else begin
            if (w_a_gnt || w_b_gnt) begin
                r_last_grant <= w_b_gnt ? PORT_B : PORT_A;
            end
            case (r_state)
                ST_RR: begin
                    if (w_b_gnt && i_b_lock) begin
                        r_lock_cnt <= 8'd1;
                        r_state    <= (LOCK_LIMIT <= 8'd1) ? ST_YIELD : ST_LOCK_B;
                    end
                end
                ST_LOCK_B: begin
                    if (!i_b_lock || !i_b_req) begin
                        r_lock_cnt <= 8'd0;
                        r_state    <= ST_RR;
                    end else begin
                        r_lock_cnt <= w_lock_inc;
                        if (w_lock_inc >= LOCK_LIMIT) begin
                            r_state <= ST_YIELD;
                        end
                    end
                end
                ST_YIELD: begin
                    r_lock_cnt <= 8'd0;
                    r_state    <= ST_RR;
                end
                default: begin
                    r_lock_cnt <= 8'd0;
                    r_state    <= ST_RR;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_a_rdata      <= 32'd0;
            r_b_rdata      <= 32'd0;
            r_a_rvalid     <= 1'b0;
            r_b_rvalid     <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            r_a_rvalid <= w_a_gnt & ~i_a_we;
            r_b_rvalid <= w_b_gnt & ~i_b_we;
            if (w_a_gnt && !i_a_we) begin
                r_a_rdata <= i_m_rdata;
            end
            if (w_b_gnt && !i_b_we) begin
                r_b_rdata <= i_m_rdata;
            end
            if (i_a_req && i_b_req && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    // When idle the memory side shows port A, so waveforms stay stable.
    assign w_own_addr = w_b_gnt ? i_b_addr : i_a_addr;

    assign w_unused_addr_bits = ^{i_a_addr[31:29], i_a_addr[1:0], i_b_addr[31:29], i_b_addr[1:0]};

    assign o_a_gnt        = w_a_gnt;
    assign o_b_gnt        = w_b_gnt;
    assign o_a_stall      = i_a_req & ~w_a_gnt;
    assign o_m_addr       = word_addr(w_own_addr);
    assign o_m_wdata      = w_b_gnt ? i_b_wdata : i_a_wdata;
    assign o_m_wr         = (w_a_gnt & i_a_we) | (w_b_gnt & i_b_we);
    assign o_a_rdata      = r_a_rdata;
    assign o_b_rdata      = r_b_rdata;
    assign o_a_rvalid     = r_a_rvalid;
    assign o_b_rvalid     = r_b_rvalid;
    assign o_conflict_cnt = r_conflict_cnt;

endmodule
